// File: rtl/dccm_port_arbiter.sv
// Arbitrates the single-ported DCCM RAM between the core LD/ST pipeline and the DMI port.
// The core has priority until the DMI has been refused DMI_MAX_WAIT times in a row, then the DMI gets one forced slot.
module dccm_port_arbiter #(
  parameter int LDST_A_MSB   = 16,
  parameter int DMI_MAX_WAIT = 8
) (
  input  logic                  clk,
  input  logic                  rst_a,
  input  logic                  core_req,
  input  logic                  core_wr,
  input  logic [3:0]            core_be,
  input  logic [LDST_A_MSB:0]   core_addr,
  input  logic [31:0]           core_wdata,
  output logic                  core_gnt,
  output logic                  core_holdup,
  output logic                  core_rvalid,
  output logic [31:0]           core_rdata,
  input  logic                  dmi_req,
  input  logic                  dmi_wr,
  input  logic [3:0]            dmi_be,
  input  logic [LDST_A_MSB:0]   dmi_addr,
  input  logic [31:0]           dmi_wdata,
  output logic                  dmi_gnt,
  output logic                  dmi_rvalid,
  output logic [31:0]           dmi_rdata,
  output logic [LDST_A_MSB:0]   ram_address,
  output logic [31:0]           ram_wr_data,
  output logic [3:0]            ram_we,
  output logic [3:0]            ram_ck_en,
  input  logic [31:0]           ram_rd_data
);

  localparam logic [7:0] MAX_WAIT = 8'(DMI_MAX_WAIT);

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_FORCE = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  wait_cnt;
  logic [7:0]  wait_cnt_nxt;
  logic [1:0]  rd_owner;
  logic [1:0]  rd_owner_nxt;

  // Grant decode; reset masks every grant so a read in flight is never launched.
  always_comb begin
    core_gnt    = 1'b0;
    dmi_gnt     = 1'b0;
    core_holdup = 1'b0;
    case (state)
      ST_ARB: begin
        core_gnt = core_req;
        dmi_gnt  = dmi_req & ~core_req;
      end
      ST_FORCE: begin
        dmi_gnt     = dmi_req;
        core_holdup = 1'b1;
      end
      default: begin
        core_gnt    = 1'b0;
        dmi_gnt     = 1'b0;
        core_holdup = 1'b0;
      end
    endcase
    if (rst_a) begin
      core_gnt    = 1'b0;
      dmi_gnt     = 1'b0;
      core_holdup = 1'b0;
    end else begin
      core_gnt    = core_gnt;
      dmi_gnt     = dmi_gnt;
      core_holdup = core_holdup;
    end
  end

  // Consecutive-refusal counter: any DMI grant or an idle DMI restarts the count.
  always_comb begin
    wait_cnt_nxt = 8'd0;
    if (dmi_req && !dmi_gnt) begin
      if (wait_cnt >= MAX_WAIT) begin
        wait_cnt_nxt = MAX_WAIT;
      end else begin
        wait_cnt_nxt = wait_cnt + 8'd1;
      end
    end else begin
      wait_cnt_nxt = 8'd0;
    end
  end

  // A forced slot lasts exactly one cycle: either the DMI is served or it has withdrawn.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_ARB: begin
        if (wait_cnt_nxt == MAX_WAIT) begin
          state_nxt = ST_FORCE;
        end else begin
          state_nxt = ST_ARB;
        end
      end
      ST_FORCE: state_nxt = ST_ARB;
      default:  state_nxt = ST_ARB;
    endcase
  end

  // RAM drive from the winner; all zero when nobody is granted.
  always_comb begin
    ram_address = '0;
    ram_wr_data = 32'd0;
    ram_we      = 4'd0;
    ram_ck_en   = 4'd0;
    if (core_gnt) begin
      ram_address = core_addr;
      ram_wr_data = core_wdata;
      ram_we      = core_be & {4{core_wr}};
      ram_ck_en   = core_be;
    end else if (dmi_gnt) begin
      ram_address = dmi_addr;
      ram_wr_data = dmi_wdata;
      ram_we      = dmi_be & {4{dmi_wr}};
      ram_ck_en   = dmi_be;
    end else begin
      ram_address = '0;
      ram_wr_data = 32'd0;
      ram_we      = 4'd0;
      ram_ck_en   = 4'd0;
    end
  end

  // Reads with be == 0 still return an rvalid so the requester's bookkeeping stays simple.
  always_comb begin
    rd_owner_nxt = {core_gnt & ~core_wr, dmi_gnt & ~dmi_wr};
  end

  // State, counter and read-owner registers.
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      state    <= ST_ARB;
      wait_cnt <= 8'd0;
      rd_owner <= 2'b00;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      rd_owner <= rd_owner_nxt;
    end
  end

  // Read data is steered to the owner and forced to zero otherwise.
  always_comb begin
    core_rvalid = rd_owner[1];
    dmi_rvalid  = rd_owner[0];
    if (rd_owner[1]) begin
      core_rdata = ram_rd_data;
    end else begin
      core_rdata = 32'd0;
    end
    if (rd_owner[0]) begin
      dmi_rdata = ram_rd_data;
    end else begin
      dmi_rdata = 32'd0;
    end
  end

endmodule
